// File: rtl/eth_mac_pe_rx_frame_parser_pkg.sv
// eth_mac_pe_rx_frame_parser_pkg: shared Ethernet rx constants, FSM encoding, status layout.
// Revision 1.0
`default_nettype none
package eth_mac_pe_rx_frame_parser_pkg;

   localparam logic [7:0]  ETH_PREAMBLE    = 8'h55;
   localparam logic [7:0]  ETH_SFD         = 8'hD5;
   localparam logic [31:0] ETH_CRC_RESIDUE = 32'hDEBB20E3;
   localparam logic [31:0] ETH_CRC_INIT    = 32'hFFFFFFFF;
   localparam logic [31:0] ETH_CRC_POLY    = 32'hEDB88320;
   localparam logic [47:0] ETH_BCAST       = 48'hFFFFFFFFFFFF;
   localparam int          DA_LEN          = 6;
   localparam int          FCS_LEN         = 4;

   localparam int STS_PHY_ERR = 3;
   localparam int STS_LEN_ERR = 2;
   localparam int STS_CRC_ERR = 1;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_PREAMBLE  = 3'd1,
      ST_DATA      = 3'd2,
      ST_FLUSH     = 3'd3,
      ST_WAIT_IDLE = 3'd4
   } rx_state_e;

   // Byte idx of a MAC address in wire order: idx 0 is [47:40].
   function automatic logic [7:0] da_byte(input logic [47:0] mac, input logic [2:0] idx);
      logic [47:0] s;
      s = mac << (8 * idx);
      return s[47:40];
   endfunction

endpackage
`default_nettype wire

// File: rtl/eth_mac_pe_rx_frame_parser_crc32.sv
// eth_crc32_d8: one-byte step of the reflected Ethernet CRC32, LSB first.
// Revision 1.0
`default_nettype none
module eth_crc32_d8
   import eth_mac_pe_rx_frame_parser_pkg::*;
(
   input  logic [31:0] crc_in,
   input  logic [7:0]  d,
   output logic [31:0] crc_out
);

   always_comb begin
      crc_out = crc_in;
      for (int i = 0; i < 8; i++) begin
         crc_out = (crc_out[0] ^ d[i]) ? ((crc_out >> 1) ^ ETH_CRC_POLY) : (crc_out >> 1);
      end
   end

endmodule
`default_nettype wire

// File: rtl/eth_mac_pe_rx_frame_parser.sv
// eth_mac_pe_rx_frame_parser: GMII rx framing, DA filter, FCS check/strip, byte forwarding.
// Revision 1.0
`default_nettype none
module eth_mac_pe_rx_frame_parser
   import eth_mac_pe_rx_frame_parser_pkg::*;
#(
   parameter int MIN_FRAME_LEN = 64,
   parameter int MAX_FRAME_LEN = 1518,
   parameter int DLY           = 6
)(
   input  logic        pe_rx_clk,
   input  logic        pe_rx_rstn,
   input  logic        gmii_rx_dv,
   input  logic        gmii_rx_er,
   input  logic [7:0]  gmii_rxd,
   input  logic        pe_rx_logic_clr,
   input  logic [47:0] r_sa_macaddr,
   input  logic        r_promisc,
   output logic [7:0]  rx_frame_byte_data,
   output logic        rx_frame_byte_data_we,
   output logic        rx_frame_byte_data_done,
   output logic [11:0] rx_frame_byte_length,
   output logic [3:0]  rx_frame_status,
   output logic        rx_frame_drop
);

   localparam int          FL_W    = $clog2(DLY);
   // Oversized frames forward at most the largest legal DA..payload.
   localparam logic [11:0] FWD_MAX = 12'(MAX_FRAME_LEN - FCS_LEN);

   rx_state_e         state_q;
   logic [11:0]       cnt_q;
   logic [11:0]       fwd_q;
   logic [31:0]       crc_q;
   logic [31:0]       crc_d;
   logic [7:0]        dly_q [DLY];
   logic              uc_q;
   logic              bc_q;
   logic              phy_q;
   logic [FL_W-1:0]   fl_q;
   logic [7:0]        data_q;
   logic              we_q;
   logic              done_q;
   logic              drop_q;
   logic [11:0]       len_q;
   logic [3:0]        sts_q;

   logic              w_da_uc;
   logic              w_da_bc;
   logic              w_miss;
   logic              w_over;
   logic [11:0]       w_cnt_inc;
   logic [11:0]       w_runt_len;
   logic [3:0]        w_status;

   eth_crc32_d8 u_crc (
      .crc_in  (crc_q),
      .d       (gmii_rxd),
      .crc_out (crc_d)
   );

   always_comb begin
      w_da_uc    = uc_q & (gmii_rxd == da_byte(r_sa_macaddr, cnt_q[2:0]));
      w_da_bc    = bc_q & (gmii_rxd == da_byte(ETH_BCAST, cnt_q[2:0]));
      w_miss     = !r_promisc && !w_da_uc && !w_da_bc;
      w_over     = cnt_q > 12'(MAX_FRAME_LEN);
      w_cnt_inc  = (cnt_q == 12'hFFF) ? cnt_q : cnt_q + 12'd1;
      w_runt_len = (cnt_q > 12'(FCS_LEN)) ? cnt_q - 12'(FCS_LEN) : 12'd0;
      w_status   = 4'd0;
      w_status[STS_PHY_ERR] = phy_q;
      w_status[STS_LEN_ERR] = (cnt_q < 12'(MIN_FRAME_LEN)) || w_over;
      w_status[STS_CRC_ERR] = crc_q != ETH_CRC_RESIDUE;
   end

   always_ff @(posedge pe_rx_clk or negedge pe_rx_rstn) begin
      if (!pe_rx_rstn) begin
         state_q <= ST_IDLE;
         cnt_q   <= 12'd0;
         fwd_q   <= 12'd0;
         crc_q   <= ETH_CRC_INIT;
         uc_q    <= 1'b0;
         bc_q    <= 1'b0;
         phy_q   <= 1'b0;
         fl_q    <= '0;
         data_q  <= 8'd0;
         we_q    <= 1'b0;
         done_q  <= 1'b0;
         drop_q  <= 1'b0;
         len_q   <= 12'd0;
         sts_q   <= 4'd0;
         for (int i = 0; i < DLY; i++) dly_q[i] <= 8'd0;
      end else if (pe_rx_logic_clr) begin
         // A frame still in progress is skipped until the line goes idle.
         state_q <= gmii_rx_dv ? ST_WAIT_IDLE : ST_IDLE;
         cnt_q   <= 12'd0;
         fwd_q   <= 12'd0;
         crc_q   <= ETH_CRC_INIT;
         uc_q    <= 1'b0;
         bc_q    <= 1'b0;
         phy_q   <= 1'b0;
         fl_q    <= '0;
         data_q  <= 8'd0;
         we_q    <= 1'b0;
         done_q  <= 1'b0;
         drop_q  <= 1'b0;
         len_q   <= 12'd0;
         sts_q   <= 4'd0;
         for (int i = 0; i < DLY; i++) dly_q[i] <= 8'd0;
      end else begin
         we_q   <= 1'b0;
         done_q <= 1'b0;
         drop_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (gmii_rx_dv && gmii_rxd == ETH_PREAMBLE) state_q <= ST_PREAMBLE;
            end
            ST_PREAMBLE: begin
               if (!gmii_rx_dv) begin
                  state_q <= ST_IDLE;
               end else if (gmii_rxd == ETH_SFD) begin
                  state_q <= ST_DATA;
                  cnt_q   <= 12'd0;
                  fwd_q   <= 12'd0;
                  crc_q   <= ETH_CRC_INIT;
                  uc_q    <= 1'b1;
                  bc_q    <= 1'b1;
                  phy_q   <= 1'b0;
                  len_q   <= 12'd0;
                  sts_q   <= 4'd0;
               end else if (gmii_rxd != ETH_PREAMBLE) begin
                  state_q <= ST_WAIT_IDLE;
               end
            end
            ST_DATA: begin
               if (gmii_rx_dv) begin
                  cnt_q <= w_cnt_inc;
                  crc_q <= crc_d;
                  phy_q <= phy_q | gmii_rx_er;
                  if (cnt_q < 12'(DA_LEN)) begin
                     uc_q <= w_da_uc;
                     bc_q <= w_da_bc;
                  end
                  if (cnt_q == 12'(DA_LEN - 1) && w_miss) begin
                     drop_q  <= 1'b1;
                     state_q <= ST_WAIT_IDLE;
                  end
                  if (fwd_q < FWD_MAX) begin
                     dly_q[0] <= gmii_rxd;
                     for (int i = 1; i < DLY; i++) dly_q[i] <= dly_q[i-1];
                     if (cnt_q >= 12'(DLY)) begin
                        we_q   <= 1'b1;
                        data_q <= dly_q[DLY-1];
                        fwd_q  <= fwd_q + 12'd1;
                     end
                  end
               end else if (!w_over && cnt_q >= 12'(DLY)) begin
                  state_q <= ST_FLUSH;
                  fl_q    <= FL_W'(DLY - 1);
               end else begin
                  // Runts and oversized frames finish without draining the line.
                  done_q  <= 1'b1;
                  len_q   <= w_over ? fwd_q : w_runt_len;
                  sts_q   <= w_status;
                  state_q <= ST_IDLE;
               end
            end
            ST_FLUSH: begin
               if (fl_q >= FL_W'(FCS_LEN)) begin
                  we_q   <= 1'b1;
                  data_q <= dly_q[fl_q];
                  fl_q   <= fl_q - 1'b1;
               end else begin
                  done_q  <= 1'b1;
                  len_q   <= cnt_q - 12'(FCS_LEN);
                  sts_q   <= w_status;
                  state_q <= ST_IDLE;
               end
            end
            ST_WAIT_IDLE: begin
               if (!gmii_rx_dv) state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign rx_frame_byte_data      = data_q;
   assign rx_frame_byte_data_we   = we_q;
   assign rx_frame_byte_data_done = done_q;
   assign rx_frame_byte_length    = len_q;
   assign rx_frame_status         = sts_q;
   assign rx_frame_drop           = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_eth_mac_pe_rx_frame_parser.sv
// tb_eth_mac_pe_rx_frame_parser: directed frames against hand-derived counts, lengths and status.
// Revision 1.0
`default_nettype none
module tb_eth_mac_pe_rx_frame_parser;

   logic        pe_rx_clk = 1'b0;
   logic        pe_rx_rstn = 1'b0;
   logic        gmii_rx_dv = 1'b0;
   logic        gmii_rx_er = 1'b0;
   logic [7:0]  gmii_rxd = 8'd0;
   logic        pe_rx_logic_clr = 1'b0;
   logic [47:0] r_sa_macaddr = 48'h020000000001;
   logic        r_promisc = 1'b0;
   logic [7:0]  rx_frame_byte_data;
   logic        rx_frame_byte_data_we;
   logic        rx_frame_byte_data_done;
   logic [11:0] rx_frame_byte_length;
   logic [3:0]  rx_frame_status;
   logic        rx_frame_drop;

   eth_mac_pe_rx_frame_parser u_dut (
      .pe_rx_clk               (pe_rx_clk),
      .pe_rx_rstn              (pe_rx_rstn),
      .gmii_rx_dv              (gmii_rx_dv),
      .gmii_rx_er              (gmii_rx_er),
      .gmii_rxd                (gmii_rxd),
      .pe_rx_logic_clr         (pe_rx_logic_clr),
      .r_sa_macaddr            (r_sa_macaddr),
      .r_promisc               (r_promisc),
      .rx_frame_byte_data      (rx_frame_byte_data),
      .rx_frame_byte_data_we   (rx_frame_byte_data_we),
      .rx_frame_byte_data_done (rx_frame_byte_data_done),
      .rx_frame_byte_length    (rx_frame_byte_length),
      .rx_frame_status         (rx_frame_status),
      .rx_frame_drop           (rx_frame_drop)
   );

   always #5 pe_rx_clk = ~pe_rx_clk;

   localparam logic [47:0] MAC_OWN   = 48'h020000000001;
   localparam logic [47:0] MAC_OTHER = 48'h020000000002;
   localparam logic [47:0] MAC_BC    = 48'hFFFFFFFFFFFF;

   logic [7:0] frm [0:1599];
   int n_chk = 0;
   int n_bad = 0;
   int frame_no = 0;

   // Monitor-owned counters; the test works with deltas of these.
   int we_tot = 0, we_idx = 0, done_cnt = 0, drop_cnt = 0, byte_bad = 0, mon_frame = 0;
   logic [11:0] cap_len = 12'd0;
   logic [3:0]  cap_sts = 4'd0;

   always @(negedge pe_rx_clk) begin
      if (pe_rx_rstn) begin
         if (mon_frame != frame_no) begin
            mon_frame = frame_no;
            we_idx = 0;
         end
         if (rx_frame_byte_data_we) begin
            if (we_idx < 1600 && rx_frame_byte_data !== frm[we_idx]) byte_bad++;
            we_idx++;
            we_tot++;
         end
         if (rx_frame_byte_data_done) begin
            done_cnt++;
            cap_len = rx_frame_byte_length;
            cap_sts = rx_frame_status;
            we_idx = 0;
         end
         if (rx_frame_drop) drop_cnt++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
      logic [31:0] r;
      r = c;
      for (int k = 0; k < 8; k++) begin
         if (r[0] ^ b[k]) r = (r >> 1) ^ 32'hEDB88320;
         else             r = r >> 1;
      end
      return r;
   endfunction

   task automatic build(input logic [47:0] da, input int n, input bit flip);
      logic [31:0] c;
      for (int i = 0; i < 6; i++) frm[i] = da[47 - 8*i -: 8];
      frm[6] = 8'h02; frm[7] = 8'h00; frm[8] = 8'h00;
      frm[9] = 8'h00; frm[10] = 8'h00; frm[11] = 8'hAA;
      frm[12] = 8'h08; frm[13] = 8'h00;
      for (int i = 14; i < n - 4; i++) frm[i] = 8'(i);
      c = 32'hFFFFFFFF;
      for (int i = 0; i < n - 4; i++) c = crc_byte(c, frm[i]);
      c = ~c;
      for (int k = 0; k < 4; k++) frm[n - 4 + k] = c[8*k +: 8];
      if (flip) frm[n - 2][3] = ~frm[n - 2][3];
   endtask

   task automatic send(input int n, input int er_at, input int clr_at, input int rst_at,
                       input bit bad_pre, input int ipg);
      frame_no++;
      for (int i = 0; i < 8; i++) begin
         @(posedge pe_rx_clk); #1;
         gmii_rx_dv = 1'b1;
         gmii_rxd   = (i == 7) ? 8'hD5 : ((bad_pre && i == 6) ? 8'hAA : 8'h55);
      end
      for (int i = 0; i < n; i++) begin
         @(posedge pe_rx_clk); #1;
         if (clr_at >= 0 && i == clr_at + 1)
            chk("clr_outs", {rx_frame_byte_data_we, rx_frame_byte_data_done, rx_frame_drop,
                             rx_frame_byte_length, rx_frame_status, rx_frame_byte_data}, 32'd0);
         if (rst_at >= 0 && i == rst_at + 1)
            chk("rst_outs", {rx_frame_byte_data_we, rx_frame_byte_data_done, rx_frame_drop,
                             rx_frame_byte_length, rx_frame_status, rx_frame_byte_data}, 32'd0);
         gmii_rxd        = frm[i];
         gmii_rx_er      = (i == er_at);
         pe_rx_logic_clr = (i == clr_at);
         if (i == rst_at) pe_rx_rstn = 1'b0;
      end
      @(posedge pe_rx_clk); #1;
      gmii_rx_dv = 1'b0; gmii_rx_er = 1'b0; gmii_rxd = 8'd0; pe_rx_logic_clr = 1'b0;
      if (rst_at >= 0) begin
         @(posedge pe_rx_clk); #1;
         pe_rx_rstn = 1'b1;
      end
      repeat (ipg) @(posedge pe_rx_clk);
   endtask

   // One frame: counts are deltas over the send, len/sts only when a done is expected.
   task automatic frame(input string tag, input int n, input int er_at, input bit bad_pre,
                        input int e_we, input int e_done, input int e_drop,
                        input int e_len, input logic [3:0] e_sts, input logic [3:0] mask);
      int w0, d0, p0, b0;
      w0 = we_tot; d0 = done_cnt; p0 = drop_cnt; b0 = byte_bad;
      send(n, er_at, -1, -1, bad_pre, 12);
      chk({tag, "_we"},    32'(we_tot - w0),     32'(e_we));
      chk({tag, "_done"},  32'(done_cnt - d0),   32'(e_done));
      chk({tag, "_drop"},  32'(drop_cnt - p0),   32'(e_drop));
      chk({tag, "_bytes"}, 32'(byte_bad - b0),   32'd0);
      if (e_done > 0) begin
         chk({tag, "_len"}, 32'(cap_len), 32'(e_len));
         chk({tag, "_sts"}, 32'(cap_sts & mask), 32'(e_sts));
      end
   endtask

   initial begin
      int d0, w0;
      repeat (3) @(posedge pe_rx_clk);
      #1;
      chk("reset_outs", {rx_frame_byte_data_we, rx_frame_byte_data_done, rx_frame_drop,
                         rx_frame_byte_length, rx_frame_status, rx_frame_byte_data}, 32'd0);
      pe_rx_rstn = 1'b1;
      repeat (2) @(posedge pe_rx_clk);

      build(MAC_OWN, 64, 1'b0);
      frame("t1_good", 64, -1, 1'b0, 60, 1, 0, 60, 4'b0000, 4'hF);

      build(MAC_BC, 64, 1'b0);
      frame("t2_bcast", 64, -1, 1'b0, 60, 1, 0, 60, 4'b0000, 4'hF);
      build(MAC_OTHER, 64, 1'b0);
      frame("t2_miss", 64, -1, 1'b0, 0, 0, 1, 0, 4'b0000, 4'hF);
      r_promisc = 1'b1;
      frame("t2_promisc", 64, -1, 1'b0, 60, 1, 0, 60, 4'b0000, 4'hF);
      r_promisc = 1'b0;

      build(MAC_OWN, 64, 1'b1);
      frame("t3_crc", 64, -1, 1'b0, 60, 1, 0, 60, 4'b0010, 4'hF);

      build(MAC_OWN, 40, 1'b0);
      frame("t4_runt", 40, -1, 1'b0, 36, 1, 0, 36, 4'b0100, 4'hF);
      build(MAC_OWN, 1600, 1'b0);
      frame("t4_long", 1600, -1, 1'b0, 1514, 1, 0, 1514, 4'b0100, 4'b0100);

      build(MAC_OWN, 64, 1'b0);
      frame("t5_phyer", 64, 20, 1'b0, 60, 1, 0, 60, 4'b1000, 4'hF);
      frame("t5_badpre", 64, -1, 1'b1, 0, 0, 0, 0, 4'b0000, 4'hF);

      d0 = done_cnt;
      send(64, -1, 30, -1, 1'b0, 12);
      chk("t6_clr_done", 32'(done_cnt - d0), 32'd0);
      frame("t6_after_clr", 64, -1, 1'b0, 60, 1, 0, 60, 4'b0000, 4'hF);

      d0 = done_cnt;
      send(64, -1, -1, 30, 1'b0, 12);
      chk("t6_rst_done", 32'(done_cnt - d0), 32'd0);
      frame("t6_after_rst", 64, -1, 1'b0, 60, 1, 0, 60, 4'b0000, 4'hF);

      d0 = done_cnt; w0 = we_tot;
      send(64, -1, -1, -1, 1'b0, 12);
      send(64, -1, -1, -1, 1'b0, 12);
      chk("t6_b2b_done", 32'(done_cnt - d0), 32'd2);
      chk("t6_b2b_we", 32'(we_tot - w0), 32'd120);
      chk("t6_b2b_len", 32'(cap_len), 32'd60);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
